// File: rtl/pll_reconfig_seq_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the reconfig IP register map, the sequencer state encoding, the
// preset record layout and the preset ROM. Counter words use
// [7:0] lo, [15:8] hi, [16] bypass, [17] odd; C words add [22:18] counter select.
// Presets assume a 50 MHz reference.
package pll_reconfig_pkg;

   localparam logic [5:0] ADDR_MODE   = 6'h00;
   localparam logic [5:0] ADDR_STATUS = 6'h01;
   localparam logic [5:0] ADDR_START  = 6'h02;
   localparam logic [5:0] ADDR_N      = 6'h03;
   localparam logic [5:0] ADDR_M      = 6'h04;
   localparam logic [5:0] ADDR_C      = 6'h05;

   typedef enum logic [3:0] {
      IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_C2, WR_START,
      POLL, POLL_GAP, WAIT_LOCK, ERR
   } state_t;

   typedef struct packed {
      logic [31:0] n;
      logic [31:0] m;
      logic [31:0] c0;
      logic [31:0] c1;
      logic [31:0] c2;
   } preset_t;

   localparam int ROM_DEPTH = 4;

   // 0: VCO 900, 90/60/50 MHz     1: VCO 900, 45/30/25 MHz
   // 2: VCO 600, 30/20/15 MHz     3: VCO 400, 10/10/10 MHz
   localparam preset_t PRESET_ROM [ROM_DEPTH] = '{
      '{n: 32'h0001_0000, m: 32'h0000_0909, c0: 32'h0000_0505, c1: 32'h0002_0807, c2: 32'h0000_0909},
      '{n: 32'h0001_0000, m: 32'h0000_0909, c0: 32'h0000_0A0A, c1: 32'h0000_0F0F, c2: 32'h0000_1212},
      '{n: 32'h0001_0000, m: 32'h0000_0606, c0: 32'h0000_0A0A, c1: 32'h0000_0F0F, c2: 32'h0000_1414},
      '{n: 32'h0001_0000, m: 32'h0000_0404, c0: 32'h0000_1414, c1: 32'h0000_1414, c2: 32'h0000_1414}
   };

   // Insert the C counter select into a stored C word.
   function automatic logic [31:0] c_word(input logic [31:0] w, input logic [4:0] sel);
      return {w[31:23], sel, w[17:0]};
   endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the sequencer and the reconfig IP.
// master: sequencer side (drives address/read/write/writedata).
// slave:  reconfig IP side (drives readdata/waitrequest).
interface pll_reconfig_seq_if;
   logic [5:0]  mgmt_address;
   logic        mgmt_read;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
      input  mgmt_readdata, mgmt_waitrequest
   );

   modport slave (
      input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
      output mgmt_readdata, mgmt_waitrequest
   );
endinterface

// File: rtl/pll_reconfig_seq_avmm.sv
// Single-transaction Avalon-MM master.
// go/rd/wr/address/data: request from the sequencer, held until ack.
// ack:   transaction completes on the coming clock edge.
// rdata: read data, valid with ack on a read.
// mgmt:  management bus (master modport).
// Purely combinational: the request is decoded from registered sequencer
// state, so the bus is stable for as long as the sequencer holds go.
module pll_reconfig_avmm (
   input  logic               go,
   input  logic               rd,
   input  logic               wr,
   input  logic [5:0]         address,
   input  logic [31:0]        data,
   output logic               ack,
   output logic [31:0]        rdata,
   pll_reconfig_seq_if.master mgmt
);

   logic do_wr;
   logic do_rd;

   // write wins if both are requested, so read and write never overlap
   assign do_wr = go & wr;
   assign do_rd = go & rd & ~wr;

   assign mgmt.mgmt_write     = do_wr;
   assign mgmt.mgmt_read      = do_rd;
   assign mgmt.mgmt_address   = (do_wr | do_rd) ? address : 6'h00;
   assign mgmt.mgmt_writedata = do_wr ? data : 32'h0;

   assign ack   = (do_wr | do_rd) & ~mgmt.mgmt_waitrequest;
   assign rdata = mgmt.mgmt_readdata;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer.
// clk/rst_n:         management clock, synchronous active-low reset.
// cfg_req/cfg_sel:   request pulse and preset index.
// busy/done/error:   in progress, one-cycle success pulse, sticky failure.
// pll_locked:        asynchronous PLL lock, synchronised here.
// mgmt:              Avalon-MM bus to the reconfig IP.
//
// state      | meaning
// IDLE       | waiting for cfg_req
// WR_MODE    | check preset index, write polling mode
// WR_N..WR_C2| write preset counter words
// WR_START   | kick off reconfiguration
// POLL       | read status until bit 0 set
// POLL_GAP   | one idle cycle between status reads
// WAIT_LOCK  | wait for LOCK_STABLE cycles of steady lock
// ERR        | flag error, back to IDLE
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_PRESETS = 4,
   parameter int TIMEOUT_CYC = 1048576,
   parameter int LOCK_STABLE = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_req,
   input  logic [1:0]         cfg_sel,
   output logic               busy,
   output logic               done,
   output logic               error,
   input  logic               pll_locked,
   pll_reconfig_seq_if.master mgmt
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

   state_t        state, next_state;
   logic [1:0]    sel_q;
   logic          lock_meta, lock_s;
   logic [TW-1:0] tmo_cnt;
   logic [SW-1:0] stab_cnt;
   logic          sel_ok, tmo_fire, stab_done;
   preset_t       preset;

   logic          go, rd, wr, ack;
   logic [5:0]    addr;
   logic [31:0]   wdata, rdata;
   logic          unused_rdata;

   assign sel_ok       = (int'(sel_q) < NUM_PRESETS);
   assign preset       = PRESET_ROM[sel_q];
   assign tmo_fire     = (tmo_cnt == '0);
   assign stab_done    = lock_s && (stab_cnt == '0);
   assign unused_rdata = ^rdata[31:1];

   pll_reconfig_avmm u_avmm (
      .go      (go),
      .rd      (rd),
      .wr      (wr),
      .address (addr),
      .data    (wdata),
      .ack     (ack),
      .rdata   (rdata),
      .mgmt    (mgmt)
   );

   always_comb begin
      next_state = state;
      go    = 1'b0;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = 6'h00;
      wdata = 32'h0;
      unique case (state)
         IDLE: if (cfg_req) next_state = WR_MODE;
         WR_MODE: begin
            if (!sel_ok) next_state = ERR;
            else begin
               go = 1'b1; wr = 1'b1; addr = ADDR_MODE; wdata = 32'd1;
               if (ack) next_state = WR_N;
            end
         end
         WR_N: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_N; wdata = preset.n;
            if (ack) next_state = WR_M;
         end
         WR_M: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_M; wdata = preset.m;
            if (ack) next_state = WR_C0;
         end
         WR_C0: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_C; wdata = c_word(preset.c0, 5'd0);
            if (ack) next_state = WR_C1;
         end
         WR_C1: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_C; wdata = c_word(preset.c1, 5'd1);
            if (ack) next_state = WR_C2;
         end
         WR_C2: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_C; wdata = c_word(preset.c2, 5'd2);
            if (ack) next_state = WR_START;
         end
         WR_START: begin
            go = 1'b1; wr = 1'b1; addr = ADDR_START; wdata = 32'h0;
            if (ack) next_state = POLL;
         end
         POLL: begin
            // timeout abandons an outstanding read by dropping go
            if (tmo_fire) next_state = ERR;
            else begin
               go = 1'b1; rd = 1'b1; addr = ADDR_STATUS;
               if (ack) next_state = rdata[0] ? WAIT_LOCK : POLL_GAP;
            end
         end
         POLL_GAP:  next_state = tmo_fire ? ERR : POLL;
         WAIT_LOCK: begin
            if (stab_done)     next_state = IDLE;
            else if (tmo_fire) next_state = ERR;
         end
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel_q     <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
         tmo_cnt   <= '0;
         stab_cnt  <= '0;
      end else begin
         state     <= next_state;
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
         done      <= 1'b0;

         if (state == IDLE && cfg_req) begin
            sel_q <= cfg_sel;
            busy  <= 1'b1;
            error <= 1'b0;
         end
         if (next_state == ERR && state != ERR) begin
            busy  <= 1'b0;
            error <= 1'b1;
         end
         if (state == WAIT_LOCK && next_state == IDLE) begin
            busy <= 1'b0;
            done <= 1'b1;
         end

         // down-counter: TIMEOUT_CYC-1 at POLL entry, fires at zero
         if (state == WR_START)
            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
         else if ((state == POLL || state == POLL_GAP || state == WAIT_LOCK) && !tmo_fire)
            tmo_cnt <= tmo_cnt - TW'(1);

         // reloads whenever lock is lost, so only an unbroken run reaches zero
         if (state != WAIT_LOCK || !lock_s)
            stab_cnt <= SW'(LOCK_STABLE - 1);
         else if (stab_cnt != '0)
            stab_cnt <= stab_cnt - SW'(1);
      end
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
module tb_pll_reconfig_seq;

   logic       clk;
   logic       rst_n;
   logic       cfg_req;
   logic [1:0] cfg_sel;
   logic       busy;
   logic       done;
   logic       error;
   logic       pll_locked;

   pll_reconfig_seq_if mgmt ();

   pll_reconfig_seq #(
      .NUM_PRESETS (3),
      .TIMEOUT_CYC (1000),
      .LOCK_STABLE (256)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_req    (cfg_req),
      .cfg_sel    (cfg_sel),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .pll_locked (pll_locked),
      .mgmt       (mgmt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // slave model state
   int          wr_stall     = 0;
   int          status_zeros = 0;
   int          stall_cnt    = 0;
   int          hold_err     = 0;
   int          excl_err     = 0;
   int          wr_hi        = 0;
   int          start_cyc    = 0;
   logic        held         = 1'b0;
   logic [38:0] held_req     = '0;
   logic [37:0] log_q [$];
   int          rd_q  [$];

   // hand-computed write sequences {address, data}
   logic [37:0] exp_p0 [7] = '{
      {6'h00, 32'h0000_0001}, {6'h03, 32'h0001_0000}, {6'h04, 32'h0000_0909},
      {6'h05, 32'h0000_0505}, {6'h05, 32'h0006_0807}, {6'h05, 32'h0008_0909},
      {6'h02, 32'h0000_0000}};
   logic [37:0] exp_p1 [7] = '{
      {6'h00, 32'h0000_0001}, {6'h03, 32'h0001_0000}, {6'h04, 32'h0000_0909},
      {6'h05, 32'h0000_0A0A}, {6'h05, 32'h0004_0F0F}, {6'h05, 32'h0008_1212},
      {6'h02, 32'h0000_0000}};

   // Avalon slave: stalls writes by wr_stall cycles, returns status 1
   // after status_zeros reads, logs completions and checks bus rules.
   initial begin
      mgmt.mgmt_waitrequest = 1'b0;
      mgmt.mgmt_readdata    = 32'h0;
      forever begin
         @(negedge clk);
         if (mgmt.mgmt_read && mgmt.mgmt_write) excl_err++;
         if (mgmt.mgmt_write) wr_hi++;
         if (mgmt.mgmt_read || mgmt.mgmt_write) begin
            if (held && ({mgmt.mgmt_write, mgmt.mgmt_address, mgmt.mgmt_writedata} !== held_req))
               hold_err++;
            if (mgmt.mgmt_write && stall_cnt < wr_stall) begin
               mgmt.mgmt_waitrequest = 1'b1;
               stall_cnt++;
               held     = 1'b1;
               held_req = {mgmt.mgmt_write, mgmt.mgmt_address, mgmt.mgmt_writedata};
            end else begin
               mgmt.mgmt_waitrequest = 1'b0;
               stall_cnt = 0;
               held      = 1'b0;
               if (mgmt.mgmt_write) begin
                  log_q.push_back({mgmt.mgmt_address, mgmt.mgmt_writedata});
                  if (mgmt.mgmt_address == 6'h02) start_cyc = cyc;
               end else begin
                  mgmt.mgmt_readdata = (rd_q.size() >= status_zeros) ? 32'd1 : 32'd0;
                  rd_q.push_back(cyc);
               end
            end
         end else begin
            mgmt.mgmt_waitrequest = 1'b0;
            stall_cnt = 0;
            held      = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      log_q.delete();
      rd_q.delete();
      wr_hi    = 0;
      hold_err = 0;
   endtask

   task automatic req(input logic [1:0] sel);
      @(negedge clk);
      cfg_req = 1'b1;
      cfg_sel = sel;
      @(negedge clk);
      cfg_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int at);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, done, 1);
      at = cyc;
   endtask

   int t;
   int rd_c;
   int rise_c;
   int n;

   initial begin
      rst_n      = 1'b0;
      cfg_req    = 1'b0;
      cfg_sel    = 2'd0;
      pll_locked = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {busy, done, error, mgmt.mgmt_read, mgmt.mgmt_write, mgmt.mgmt_address, mgmt.mgmt_writedata},
            41'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // preset 0, no stalls, immediate status, lock steady; stray request while busy
      clear_logs();
      req(2'd0);
      check("p0_busy_after_accept", busy, 1);
      check("p0_error_after_accept", error, 0);
      repeat (2) @(negedge clk);
      cfg_req = 1'b1;
      cfg_sel = 2'd2;
      @(negedge clk);
      cfg_req = 1'b0;
      wait_done("p0", t);
      // done rises LOCK_STABLE edges after the edge completing the status read
      check("p0_done_latency", t - rd_q[$] - 1, 256);
      check("p0_busy_at_done", busy, 0);
      @(negedge clk);
      check("p0_done_one_cycle", done, 0);
      check("p0_write_count", log_q.size(), 7);
      for (int i = 0; i < 7; i++) check($sformatf("p0_write%0d", i), log_q[i], exp_p0[i]);
      check("p0_read_count", rd_q.size(), 1);
      check("p0_error_clear", error, 0);

      // preset 1 with 5 stall cycles per write
      wr_stall = 5;
      clear_logs();
      req(2'd1);
      wait_done("p1", t);
      wr_stall = 0;
      check("p1_write_count", log_q.size(), 7);
      for (int i = 0; i < 7; i++) check($sformatf("p1_write%0d", i), log_q[i], exp_p1[i]);
      check("p1_hold_stable", hold_err, 0);
      check("p1_write_high_cycles", wr_hi, 42);

      // preset 2, status 0 three times then 1
      status_zeros = 3;
      clear_logs();
      req(2'd2);
      wait_done("p2", t);
      status_zeros = 0;
      check("p2_read_count", rd_q.size(), 4);
      for (int i = 0; i < 3; i++) check($sformatf("p2_read_gap%0d", i), rd_q[i+1] - rd_q[i], 2);
      check("p2_m_word", log_q[2], {6'h04, 32'h0000_0606});
      check("p2_c0_word", log_q[3], {6'h05, 32'h0000_0A0A});

      // lock drops at stable count 200, then stays high
      clear_logs();
      req(2'd0);
      n = 0;
      while (rd_q.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("lk_status_read_seen", rd_q.size(), 1);
      rd_c = rd_q[$];
      n = 0;
      while (cyc < rd_c + 201 && n < 400) begin
         @(negedge clk);
         n++;
      end
      pll_locked = 1'b0;
      repeat (5) @(negedge clk);
      check("lk_no_done_while_low", done, 0);
      pll_locked = 1'b1;
      rise_c = cyc;
      wait_done("lk", t);
      // first sampling edge, two synchroniser stages, then LOCK_STABLE edges
      check("lk_done_latency", t - rise_c, 258);

      // status never completes: timeout after 1000 cycles in POLL
      status_zeros = 1000000;
      clear_logs();
      req(2'd0);
      n = 0;
      while (!error && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("to_error_set", error, 1);
      check("to_latency", cyc - start_cyc - 1, 1000);
      check("to_busy_low", busy, 0);
      check("to_read_dropped", mgmt.mgmt_read, 0);
      check("to_read_count", rd_q.size(), 500);
      status_zeros = 0;
      clear_logs();
      req(2'd1);
      check("to_error_cleared", error, 0);
      check("to_busy_again", busy, 1);
      wait_done("to_retry", t);

      // index beyond NUM_PRESETS
      clear_logs();
      req(2'd3);
      check("bad_sel_busy", busy, 1);
      n = 0;
      while (!error && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bad_sel_error", error, 1);
      check("bad_sel_busy_low", busy, 0);
      check("bad_sel_no_writes", log_q.size(), 0);
      check("bad_sel_no_reads", rd_q.size(), 0);
      repeat (3) @(negedge clk);
      check("bad_sel_sticky", error, 1);

      // reset while WR_M is stalled
      wr_stall = 5;
      clear_logs();
      req(2'd0);
      n = 0;
      while (!(mgmt.mgmt_write && mgmt.mgmt_address == 6'h04) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_in_wr_m", {mgmt.mgmt_write, mgmt.mgmt_address}, {1'b1, 6'h04});
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs",
            {busy, done, error, mgmt.mgmt_read, mgmt.mgmt_write, mgmt.mgmt_address, mgmt.mgmt_writedata},
            41'h0);
      rst_n    = 1'b1;
      wr_stall = 0;
      repeat (3) @(negedge clk);
      check("rst_stays_idle", {busy, mgmt.mgmt_write}, 2'b00);
      check("rw_exclusive", excl_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer upstream of the Cyclone V PLL reconfiguration IP; that IP drives the PLL wrapper's reconfig_to_pll bus.
- On request, writes one of several pre-computed counter presets (N, M, C0..C2) over the Avalon-MM management port.
- Then starts reconfiguration, polls for completion and waits for a stable PLL lock.
- Lets the CPU clock move between presets, e.g. 90/60/50 MHz and slower turbo-off settings, without rebuilding the core.

Parameters:
- NUM_PRESETS, 4: number of valid preset entries; cfg_sel >= NUM_PRESETS is rejected.
- TIMEOUT_CYC, 1048576: maximum cycles allowed in POLL or WAIT_LOCK before error.
- LOCK_STABLE, 256: consecutive cycles pll_locked must be high before done.

Ports:
- clk  in  1  system clock; the management clock of the reconfig IP.
- rst_n  in  1  synchronous active-low reset.
- cfg_req  in  1  single-cycle request pulse.
- cfg_sel  in  2  preset index; sampled on an accepted cfg_req.
- busy  out  1  high from accept until done/error.
- done  out  1  one-cycle pulse on successful relock.
- error  out  1  sticky; cleared on the next accepted cfg_req.
- pll_locked  in  1  PLL locked; asynchronous, synchronised internally.
- mgmt_address  out  6  reconfig register address.
- mgmt_read  out  1  Avalon read.
- mgmt_write  out  1  Avalon write.
- mgmt_writedata  out  32  write data.
- mgmt_readdata  in  32  read data.
- mgmt_waitrequest  in  1  Avalon stall.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; busy=0, done=0, error=0, mgmt_read=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0; counters 0; 2-FF lock synchroniser cleared. Reset mid-transaction drops read/write at that edge; no completion is required.
- Request accept:
  - cfg_req is accepted only in IDLE. The accepting cycle latches cfg_sel, clears error and sets busy next cycle.
  - cfg_req while busy is ignored.
  - If the latched sel >= NUM_PRESETS: go to ERR. No bus access occurs.
- Write states, in order (address, data):
  - WR_MODE (0x00, 1): polling mode.
  - WR_N (0x03, preset N word).
  - WR_M (0x04, preset M word).
  - WR_C0 (0x05, C word, counter select 0).
  - WR_C1 (0x05, C word, counter select 1).
  - WR_C2 (0x05, C word, counter select 2).
  - WR_START (0x02, 0).
- Avalon handshake:
  - mgmt_write, mgmt_address and mgmt_writedata are asserted and held stable until a cycle with mgmt_waitrequest=0; the write completes on that edge.
  - The next state's write may start on the following cycle.
  - Only one of mgmt_read/mgmt_write is ever high.
- POLL:
  - Read address 0x01, with the same hold rule.
  - On a completing read with readdata[0]=1, go to WAIT_LOCK.
  - Otherwise deassert read for 1 cycle and re-issue.
- WAIT_LOCK:
  - A stable counter increments while synced lock=1 and resets to 0 when lock=0.
  - When the counter reaches LOCK_STABLE-1 with lock high: done=1 for one cycle, busy=0, return to IDLE.
- Timeout:
  - A timeout counter clears on entry to POLL and counts through POLL and WAIT_LOCK.
  - On reaching TIMEOUT_CYC-1, go to ERR: error=1, busy=0, IDLE next cycle.
  - A read in flight when the timeout fires is abandoned (read deasserted).
  - Write states have no timeout.
- Preset word formats:
  - M/N word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd.
  - C word: the same fields plus [22:18] counter select.
- Widths: counters are sized from the parameters via $clog2; no wrap is possible before the terminal value.

Decomposition:
- Package pll_reconfig_pkg holds:
  - register address constants;
  - the state enum;
  - the preset struct (n, m, c0, c1, c2 words) and the preset ROM constant.
- Preset 0 is 90 MHz:
  - N bypass; M hi/lo 9/9 (VCO 900).
  - C0 5/5; C1 8/7 odd (60 MHz); C2 9/9 (50 MHz).
- One sub-module, pll_reconfig_avmm, is the single-transaction Avalon master. Inputs: go, rd/wr, address, data. Outputs: ack and rdata. It enforces the hold and mutual-exclusion rules.

Test Plan:
- Preset 0, waitrequest always 0, status=1 on first read, locked high: write sequence 0x00/1, 0x03/0x10000, 0x04/0x0909, 0x05 x3, 0x02/0. done is asserted exactly LOCK_STABLE cycles after the status read, plus synchroniser latency.
- waitrequest held high 5 cycles on each write: address and data stay stable for all 6 cycles; no write is duplicated or skipped.
- Status returns 0 three times, then 1: exactly 4 reads with a 1-cycle gap between them; then WAIT_LOCK.
- pll_locked toggles low at stable count 200, then stays high: the counter restarts; done arrives 256 cycles after the last rising edge.
- Status is never 1 (TIMEOUT_CYC=1000 for the test): error=1 and busy=0 after 1000 cycles in POLL. The next cfg_req clears error.
- cfg_sel=3 with NUM_PRESETS=3: error with no mgmt access. A cfg_req pulse during busy is ignored. Asserting rst_n=0 during WR_M clears all outputs next edge.
